reg_cmd_decoder: RTL and testbench

REG_CMD_DECODER -- requirements
Module: reg_cmd_decoder

---
 rtl/reg_cmd_decoder.sv | 145 ++++++++++++++
 tb/tb_reg_cmd_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_decoder.sv
// reg_cmd_decoder
//   Decodes 3-byte command frames (ADDR, LOW, HIGH) from a byte stream into a
//   one-hot load strobe plus a 16-bit data word for a bank of shadow registers.
//   ADDR byte: [7:4] must be the sync nibble 4'hA, [3:0] is the register index.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_data_i   received command byte
//   rx_valid_i  rx_data_i valid this cycle
//   rx_ready_o  decoder accepts a byte this cycle (low only in COMMIT)
//   set_o       one-hot load strobe, high only in COMMIT for an in-range index
//   din_l_o     low data byte to all shadow registers
//   din_h_o     high data byte to all shadow registers
//   busy_o      frame in progress (state other than IDLE)
//   err_o       one-cycle pulse on framing, address or timeout error
//   cmd_cnt_o   count of committed frames, wraps 255 -> 0
module reg_cmd_decoder #(
  parameter int NREG    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  output logic [NREG-1:0] set_o,
  output logic [7:0]      din_l_o,
  output logic [7:0]      din_h_o,
  output logic            busy_o,
  output logic            err_o,
  output logic [7:0]      cmd_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GET_L, GET_H, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q;
  logic [7:0]    low_stage_q;
  logic [7:0]    din_l_q, din_h_q;
  logic          err_q, err_d;
  logic [7:0]    cnt_q;
  logic [TW-1:0] tout_q;

  logic xfer;
  logic sync_ok;
  logic waiting;
  logic tout_hit;

  function automatic logic idx_in_range(input logic [3:0] idx);
    return ({1'b0, idx} < 5'(NREG));
  endfunction

  assign xfer    = rx_valid_i && (state_q != COMMIT);
  assign sync_ok = (rx_data_i[7:4] == 4'hA);
  assign waiting = (state_q == GET_L) || (state_q == GET_H);
  // The counter would reach TIMEOUT on this edge; a transfer in the same
  // cycle wins and the frame carries on.
  assign tout_hit = waiting && !xfer && (tout_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic (also forms the registered error request)
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sync_ok) state_d = GET_L;
          else         err_d   = 1'b1;
        end
      end
      GET_L: begin
        if (xfer)          state_d = GET_H;
        else if (tout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_H: begin
        if (xfer) begin
          state_d = COMMIT;
          // Out-of-range index: error is visible during the COMMIT cycle.
          err_d   = !idx_in_range(idx_q);
        end else if (tout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready_o = (state_q != COMMIT);
    busy_o     = (state_q != IDLE);
    set_o      = '0;
    if (state_q == COMMIT) begin
      for (int k = 0; k < NREG; k++) set_o[k] = (idx_q == 4'(k));
    end
  end

  assign din_l_o   = din_l_q;
  assign din_h_o   = din_h_q;
  assign err_o     = err_q;
  assign cmd_cnt_o = cnt_q;

  // Frame datapath. The low byte is staged and only moved to din_l_o together
  // with the high byte, so a timed-out partial frame never disturbs din_*_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      low_stage_q <= '0;
      din_l_q     <= '0;
      din_h_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tout_q      <= '0;
    end else begin
      err_q <= err_d;

      if (state_q == IDLE && xfer && sync_ok) idx_q <= rx_data_i[3:0];
      if (state_q == GET_L && xfer)           low_stage_q <= rx_data_i;
      if (state_q == GET_H && xfer) begin
        din_l_q <= low_stage_q;
        din_h_q <= rx_data_i;
      end

      if (state_q == COMMIT && idx_in_range(idx_q)) cnt_q <= cnt_q + 8'd1;

      if (waiting && !xfer && !tout_hit) tout_q <= tout_q + TW'(1);
      else                               tout_q <= '0;
    end
  end

endmodule

// File: tb/tb_reg_cmd_decoder.sv
module tb_reg_cmd_decoder;

  localparam int NREG    = 4;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic            rx_ready_o;
  logic [NREG-1:0] set_o;
  logic [7:0]      din_l_o, din_h_o;
  logic            busy_o, err_o;
  logic [7:0]      cmd_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  reg_cmd_decoder #(.NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready_o),
    .set_o      (set_o),
    .din_l_o    (din_l_o),
    .din_h_o    (din_h_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .cmd_cnt_o  (cmd_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] lo;
    logic [7:0] hi;
    int         gap;
    logic [3:0] set;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one byte after `gap` idle cycles; returns 1 time unit after the
  // transfer edge.
  task automatic send(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rx_ready_wait", {31'd0, rx_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    int         idx;
    logic [3:0] es;

    vecs[0] = '{8'hA2, 8'h34, 8'h12, 0, 4'b0100, 1'b0, 8'd1};
    vecs[1] = '{8'hA0, 8'hFF, 8'h00, 0, 4'b0001, 1'b0, 8'd2};
    vecs[2] = '{8'hA7, 8'h11, 8'h22, 0, 4'b0000, 1'b1, 8'd2};
    vecs[3] = '{8'hA3, 8'hAB, 8'hCD, 3, 4'b1000, 1'b0, 8'd3};
    vecs[4] = '{8'hA1, 8'h00, 8'hFF, TIMEOUT - 1, 4'b0010, 1'b0, 8'd4};
    vecs[5] = '{8'hAF, 8'h01, 8'h02, 1, 4'b0000, 1'b1, 8'd4};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_set", {28'd0, set_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_cnt", {24'd0, cmd_cnt_o}, 32'd0);
    check("rst_din", {16'd0, din_h_o, din_l_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", {31'd0, rx_ready_o}, 32'd1);

    // Bad sync nibble in IDLE
    send(8'h52, 0);
    check("bad_err", {31'd0, err_o}, 32'd1);
    check("bad_busy", {31'd0, busy_o}, 32'd0);
    check("bad_set", {28'd0, set_o}, 32'd0);
    @(posedge clk);
    #1;
    check("bad_err_clr", {31'd0, err_o}, 32'd0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].addr, vecs[v].gap);
      check("busy_get_l", {31'd0, busy_o}, 32'd1);
      send(vecs[v].lo, vecs[v].gap);
      send(vecs[v].hi, vecs[v].gap);
      check($sformatf("v%0d_set", v), {28'd0, set_o}, {28'd0, vecs[v].set});
      check($sformatf("v%0d_din_l", v), {24'd0, din_l_o}, {24'd0, vecs[v].lo});
      check($sformatf("v%0d_din_h", v), {24'd0, din_h_o}, {24'd0, vecs[v].hi});
      check($sformatf("v%0d_err", v), {31'd0, err_o}, {31'd0, vecs[v].err});
      check($sformatf("v%0d_ready", v), {31'd0, rx_ready_o}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", v), {24'd0, cmd_cnt_o}, {24'd0, vecs[v].cnt});
      check($sformatf("v%0d_set_clr", v), {28'd0, set_o}, 32'd0);
      check($sformatf("v%0d_err_clr", v), {31'd0, err_o}, 32'd0);
      check($sformatf("v%0d_busy_clr", v), {31'd0, busy_o}, 32'd0);
    end

    // Timeout in GET_H: TIMEOUT idle cycles abandon the frame
    send(8'hA1, 0);
    send(8'h55, 0);
    for (int i = 0; i <= TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("to_err_%0d", i), {31'd0, err_o}, {31'd0, (i == TIMEOUT - 1)});
      check($sformatf("to_busy_%0d", i), {31'd0, busy_o}, {31'd0, (i < TIMEOUT - 1)});
      check($sformatf("to_set_%0d", i), {28'd0, set_o}, 32'd0);
    end
    check("to_din_l", {24'd0, din_l_o}, 32'h01);
    check("to_din_h", {24'd0, din_h_o}, 32'h02);
    check("to_cnt", {24'd0, cmd_cnt_o}, 32'd4);

    // Reset while in GET_H
    send(8'hA2, 0);
    send(8'h34, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_set", {28'd0, set_o}, 32'd0);
    check("mid_rst_din", {16'd0, din_h_o, din_l_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_err", {31'd0, err_o}, 32'd0);
    check("mid_rst_cnt", {24'd0, cmd_cnt_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_set", {28'd0, set_o}, 32'd0);
      check("post_rst_ready", {31'd0, rx_ready_o}, 32'd1);
    end

    // 256 frames with random gaps below TIMEOUT: counter wraps to 0
    for (int f = 0; f < 256; f++) begin
      idx = $urandom_range(0, NREG - 1);
      es  = 4'b0001 << idx;
      send({4'hA, 4'(idx)}, $urandom_range(0, TIMEOUT - 1));
      send(8'(f), $urandom_range(0, TIMEOUT - 1));
      send(8'(255 - f), $urandom_range(0, TIMEOUT - 1));
      check($sformatf("wrap_set_%0d", f), {28'd0, set_o}, {28'd0, es});
      check($sformatf("wrap_din_%0d", f), {16'd0, din_h_o, din_l_o}, {16'd0, 8'(255 - f), 8'(f)});
      if (f == 255) check("cnt_255", {24'd0, cmd_cnt_o}, 32'd255);
    end
    @(posedge clk);
    #1;
    check("cnt_wrap", {24'd0, cmd_cnt_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
